cpu_run_ctrl: RTL and testbench

//   Synthesisable run controller for the single-cycle CPU: sequences CPU reset, the one-cycle

---
 rtl/cpu_run_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the single-cycle CPU.
// It sequences the CPU reset, the one-cycle PC load, free-run with an optional
// cycle limit, single-step, and PC breakpoints.
// Build option: define CPU_RUN_BP_EN to build the BP_N PC breakpoint comparators.
// Without it, bp_addr, bp_en and pc are ignored and bp_hit stays 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | CPU held in reset, waiting for start
// CRST   | CPU reset held for RST_CYCLES cycles after start
// LOAD   | one-cycle set_pc strobe; counts as the first CPU cycle
// RUN    | free-run; leaves on limit, halt_req or breakpoint
// STEP   | one CPU cycle requested from HALT
// HALT   | CPU stopped, done=1; accepts step or start
module cpu_run_ctrl #(
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4,
  parameter int BP_N       = 2
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 halt_req,
  input  logic [CNT_W-1:0]     run_limit,
  input  logic [PC_W-1:0]      pc,
  input  logic [BP_N*PC_W-1:0] bp_addr,
  input  logic [BP_N-1:0]      bp_en,
  output logic                 cpu_rst,
  output logic                 set_pc,
  output logic                 cpu_en,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic                 done,
  output logic [BP_N-1:0]      bp_hit
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CRST = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_STEP = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t           state;
  logic [RC_W-1:0]  rst_cnt;
  logic [CNT_W-1:0] limit_q;
  logic             cpu_en_q;
  logic [BP_N-1:0]  bp_match;
  logic             bp_stop;
  logic             limit_hit;
  logic [CNT_W-1:0] cnt_next;

`ifdef CPU_RUN_BP_EN
  // Per-comparator PC match against enabled breakpoint addresses
  always_comb begin
    bp_match = '0;
    for (int i = 0; i < BP_N; i++) begin
      bp_match[i] = bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W]);
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_en};
  assign bp_match  = '0;
`endif

  // A breakpoint must stop the instruction at pc from executing. The match is
  // only known during the cycle itself, so the registered enable is gated here.
  assign bp_stop   = (state == S_RUN) && (|bp_match);
  assign cpu_en    = cpu_en_q && !bp_stop;

  // cycle_cnt holds the number of completed CPU cycles, so the current cycle is cycle_cnt+1
  assign limit_hit = (limit_q != '0) && ((cycle_cnt + CNT_W'(1)) == limit_q);
  assign cnt_next  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

  // Sequencer: state plus all registered outputs
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      rst_cnt   <= '0;
      limit_q   <= '0;
      cpu_rst   <= 1'b1;
      set_pc    <= 1'b0;
      cpu_en_q  <= 1'b0;
      cycle_cnt <= '0;
      done      <= 1'b0;
      bp_hit    <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state     <= S_CRST;
            rst_cnt   <= RC_LOAD;
            limit_q   <= run_limit;
            cycle_cnt <= '0;
            bp_hit    <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
          end else if (step && (state == S_HALT)) begin
            state    <= S_STEP;
            cpu_en_q <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_CRST: begin
          if (rst_cnt == '0) begin
            state    <= S_LOAD;
            cpu_rst  <= 1'b0;
            set_pc   <= 1'b1;
            cpu_en_q <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - RC_W'(1);
          end
        end
        S_LOAD: begin
          set_pc    <= 1'b0;
          cycle_cnt <= cnt_next;
          if (limit_hit) begin
            state    <= S_HALT;
            cpu_en_q <= 1'b0;
            done     <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bp_stop) begin
            state    <= S_HALT;
            cpu_en_q <= 1'b0;
            done     <= 1'b1;
            bp_hit   <= bp_match;
          end else begin
            cycle_cnt <= cnt_next;
            if (limit_hit || halt_req) begin
              state    <= S_HALT;
              cpu_en_q <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        S_STEP: begin
          state     <= S_HALT;
          cycle_cnt <= cnt_next;
          cpu_en_q  <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          cpu_rst  <= 1'b1;
          set_pc   <= 1'b0;
          cpu_en_q <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed and randomized checks of cpu_run_ctrl against an
// interval model. Each start gives a reset window, one load cycle, N enabled
// cycles, and then HALT. N comes from the limit, halt_req and breakpoint rules.
module tb_cpu_run_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 6;
  localparam int R     = 4;
  localparam int BP_N  = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic                 clk;
  logic                 Reset;
  logic                 start;
  logic                 step;
  logic                 halt_req;
  logic [CNT_W-1:0]     run_limit;
  logic [PC_W-1:0]      pc;
  logic [BP_N*PC_W-1:0] bp_addr;
  logic [BP_N-1:0]      bp_en;
  logic                 cpu_rst;
  logic                 set_pc;
  logic                 cpu_en;
  logic [CNT_W-1:0]     cycle_cnt;
  logic                 done;
  logic [BP_N-1:0]      bp_hit;

  int total = 0;
  int bad   = 0;
  int g_n   = 0;
  logic [BP_N-1:0] g_hit = '0;

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(R), .BP_N(BP_N)) dut (
    .clk(clk), .Reset(Reset), .start(start), .step(step), .halt_req(halt_req),
    .run_limit(run_limit), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_rst(cpu_rst), .set_pc(set_pc), .cpu_en(cpu_en), .cycle_cnt(cycle_cnt),
    .done(done), .bp_hit(bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] sat(input int x);
    return (x > MAXC) ? CNT_W'(MAXC) : CNT_W'(x);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One start-to-HALT sequence. The abstract CPU runs from pc 0 and advances by 4 per cycle.
  task automatic run_seq(input string name, input int lim, input int hat, input bit noise,
                         input bit with_step, input logic [BP_N*PC_W-1:0] bpa,
                         input logic [BP_N-1:0] bpe);
    int n;
    int extra;
    logic [BP_N-1:0] hitm;
    logic [BP_N-1:0] m;
    logic [3:0] exp_v;
    int ce;
    n = 0; extra = 0; hitm = '0;
    for (int j = 1; j < 200; j++) begin
      m = '0;
`ifdef CPU_RUN_BP_EN
      for (int i = 0; i < BP_N; i++)
        if (bpe[i] && bpa[i*PC_W +: PC_W] == PC_W'(4*(j-1))) m[i] = 1'b1;
`endif
      if (j >= 2 && m != '0) begin
        n = j - 1; extra = 1; hitm = m; break;
      end
      if ((lim != 0 && j == lim) || (j >= 2 && j == hat)) begin
        n = j; break;
      end
    end

    run_limit = CNT_W'(lim); bp_addr = bpa; bp_en = bpe;
    start = 1'b1; step = with_step; halt_req = 1'b0; pc = '0;
    @(posedge clk); #1;
    start = 1'b0; step = 1'b0;
    run_limit = CNT_W'($urandom);
    for (int k = 1; k <= R + n + 2 + extra; k++) begin
      pc = (k >= R + 1) ? PC_W'(4*(k-R-1)) : '0;
      halt_req = (hat >= 2) && (k == R + hat);
      if (noise && k <= R + n) begin
        start = 1'($urandom_range(0, 1));
        step  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0; step = 1'b0;
      end
      #1;
      exp_v = {(k >= 1 && k <= R), (k == R + 1), (k >= R + 1 && k <= R + n),
               (k >= R + n + 1 + extra)};
      chk($sformatf("%s_ctl_k%0d", name, k), 64'({cpu_rst, set_pc, cpu_en, done}), 64'(exp_v));
      ce = (k <= R + 1) ? 0 : ((k - R - 1 < n) ? k - R - 1 : n);
      chk($sformatf("%s_cnt_k%0d", name, k), 64'(cycle_cnt), 64'(sat(ce)));
      @(posedge clk); #1;
    end
    start = 1'b0; step = 1'b0; halt_req = 1'b0;
    chk($sformatf("%s_bphit", name), 64'(bp_hit), 64'(hitm));
    g_n = n; g_hit = hitm;
  endtask

  // One step from HALT. pc is held at pcv, so a breakpoint there must not stop it.
  task automatic do_step(input string name, input logic [PC_W-1:0] pcv);
    step = 1'b1; pc = pcv;
    @(posedge clk); #1;
    step = 1'b0;
    #1;
    chk({name, "_pulse"}, 64'({cpu_rst, set_pc, cpu_en, done}), 64'(4'b0010));
    @(posedge clk); #2;
    chk({name, "_after"}, 64'({cpu_rst, set_pc, cpu_en, done}), 64'(4'b0001));
    g_n++;
    chk({name, "_cnt"}, 64'(cycle_cnt), 64'(sat(g_n)));
    chk({name, "_bphit"}, 64'(bp_hit), 64'(g_hit));
  endtask

  initial begin
    int lim;
    int hat;
    int ns;
    Reset = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0;
    run_limit = '0; pc = '0; bp_addr = '0; bp_en = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 64'({cpu_rst, set_pc, cpu_en, done}), 64'(4'b1000));
    chk("rst_cnt", 64'(cycle_cnt), 64'd0);
    chk("rst_bphit", 64'(bp_hit), 64'd0);
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ctl", 64'({cpu_rst, set_pc, cpu_en, done}), 64'(4'b1000));

    run_seq("lim5", 5, 0, 1'b0, 1'b0, '0, '0);
    run_seq("halt10", 0, 10, 1'b0, 1'b0, '0, '0);
    run_seq("lim_and_halt", 7, 7, 1'b0, 1'b0, '0, '0);
    run_seq("bp", 20, 0, 1'b0, 1'b0, {32'h0000000C, 32'h00000004}, 2'b10);
    do_step("step1", 32'h0000000C);
    do_step("step2", 32'h0000000C);
    do_step("step3", 32'h0000000C);
    run_seq("start_step", 1, 0, 1'b0, 1'b1, '0, '0);
    run_seq("lim1", 1, 0, 1'b0, 1'b0, '0, '0);

    for (int r = 0; r < 8; r++) begin
      lim = $urandom_range(0, 30);
      hat = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 35) : 0;
      if (lim == 0 && hat == 0) hat = 12;
      run_seq($sformatf("rnd%0d", r), lim, hat, 1'b1, 1'b0, '0, '0);
      ns = $urandom_range(0, 2);
      for (int s = 0; s < ns; s++) do_step($sformatf("rnd%0d_step%0d", r, s), PC_W'($urandom));
    end

    run_seq("sat", 0, 70, 1'b0, 1'b0, '0, '0);
    do_step("sat_step", 32'h0);

    // Async reset in the middle of a free run
    run_limit = '0; bp_en = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (R + 3) @(posedge clk);
    #1;
    chk("pre_rst_run", 64'({cpu_rst, cpu_en, done}), 64'(3'b010));
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_ctl", 64'({cpu_rst, set_pc, cpu_en, done}), 64'(4'b1000));
    chk("mid_rst_cnt", 64'(cycle_cnt), 64'd0);
    chk("mid_rst_bphit", 64'(bp_hit), 64'd0);
    @(posedge clk); #1;
    Reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ctl", 64'({cpu_rst, set_pc, cpu_en, done}), 64'(4'b1000));
    run_seq("post_rst_lim3", 3, 0, 1'b0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
